// File: rtl/addsub_pipe_lanes.sv
// -----------------------------------------------------------------------------
// addsub_pipe_lanes
//
// Multi-lane pipelined unsigned add/subtract unit with valid/ready handshakes
// on both sides. Each accepted beat carries LANES independent W-bit operand
// pairs and one op bit shared by all lanes. Results appear STAGES cycles after
// acceptance, with optional unsigned saturation, per-lane overflow flags and a
// sticky overflow status register.
//
// Parameters
//   W       lane operand/result width (>= 2)
//   LANES   number of independent lanes (>= 1)
//   STAGES  accept-to-out_valid latency in cycles (>= 1)
//   SAT     0 = wrap modulo 2^W, 1 = unsigned saturate
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand beat valid
//   in_ready    unit can accept a beat this cycle (depends only on output side)
//   op          0 = add (a+b), 1 = subtract (a-b); sampled with the beat
//   a, b        lane i operand at [i*W +: W]
//   out_valid   result beat valid
//   out_ready   consumer accepts result
//   y           lane results, same packing as a
//   ovf         per-lane overflow/underflow of the presented result
//   ovf_sticky  OR of ovf over all transferred results since clear/reset
//   clr_sticky  synchronous clear of ovf_sticky (a same-cycle set wins)
// -----------------------------------------------------------------------------
module addsub_pipe_lanes #(
    parameter int W      = 16,
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [LANES*W-1:0]   a,
    input  logic [LANES*W-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   y,
    output logic [LANES-1:0]     ovf,
    output logic [LANES-1:0]     ovf_sticky,
    input  logic                 clr_sticky
);

    // -------------------------------------------------------------------------
    // Per-lane arithmetic. Returns {flag, result}. The (W+1)-bit intermediate
    // makes bit W the carry on add and the borrow (x < z) on subtract, so a
    // single bit serves as the overflow/underflow flag for both operations.
    // -------------------------------------------------------------------------
    function automatic logic [W:0] lane_calc(
        input logic [W-1:0] x,
        input logic [W-1:0] z,
        input logic         sub
    );
        logic [W:0]   wide;
        logic         flag;
        logic [W-1:0] res;
        wide = sub ? ({1'b0, x} - {1'b0, z}) : ({1'b0, x} + {1'b0, z});
        flag = wide[W];
        res  = wide[W-1:0];
        // Saturate toward the bound that was crossed: all-ones on add carry,
        // zero on subtract borrow.
        if ((SAT != 0) && flag) begin
            res = sub ? '0 : '1;
        end
        return {flag, res};
    endfunction

    // -------------------------------------------------------------------------
    // Stage-1 next values, computed straight from the input beat.
    // -------------------------------------------------------------------------
    logic [LANES*W-1:0] res_d;
    logic [LANES-1:0]   ovf_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        res_d = '0;
        ovf_d = '0;
        for (int l = 0; l < LANES; l++) begin
            {ovf_d[l], res_d[l*W +: W]} = lane_calc(a[l*W +: W], b[l*W +: W], op);
        end
    end

    // -------------------------------------------------------------------------
    // Pipeline. Index 0 is stage 1; index STAGES-1 is the output register.
    // All stages move together when the output slot is free or being drained;
    // otherwise everything holds, bubbles included.
    // -------------------------------------------------------------------------
    logic [STAGES-1:0]  vld_q;
    logic [LANES*W-1:0] y_q   [STAGES];
    logic [LANES-1:0]   ovf_q [STAGES];
    logic               advance;

    assign out_valid = vld_q[STAGES-1];
    assign y         = y_q[STAGES-1];
    assign ovf       = ovf_q[STAGES-1];

    // Ready is a pure function of the output side: no in_valid dependency and
    // no combinational path from in_* to out_*.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset along with the valid bits so
            // y and ovf read 0 out of reset rather than leftover contents.
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                y_q[s]   <= '0;
                ovf_q[s] <= '0;
            end
        end else if (advance) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's pre-edge value.
            vld_q[0] <= in_valid;
            // Data slots only load under a valid beat, so a bubble moving into
            // the output leaves y/ovf at their last presented value.
            if (in_valid) begin
                y_q[0]   <= res_d;
                ovf_q[0] <= ovf_d;
            end
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    y_q[s]   <= y_q[s-1];
                    ovf_q[s] <= ovf_q[s-1];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow status. Clear is applied first and the transfer's flags
    // are ORed in afterwards, so a same-cycle set wins for those bits.
    // -------------------------------------------------------------------------
    logic             out_xfer;
    logic [LANES-1:0] sticky_d;
    logic [LANES-1:0] sticky_q;

    assign out_xfer   = out_valid && out_ready;
    assign ovf_sticky = sticky_q;

    always_comb begin
        sticky_d = clr_sticky ? '0 : sticky_q;
        if (out_xfer) begin
            sticky_d = sticky_d | ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

endmodule
